// File: rtl/lavadora_ciclo_if.sv
// Signal bundle between the payment controller / door sensor side and the
// washer cycle executor: service request pulses in, actuator and status outputs back.
interface lavadora_ciclo_if;
    logic       SECADO;
    logic       LAVADO;
    logic       LAVADO_PESADO;
    logic       puerta_cerrada;
    logic       ocupado;
    logic       valvula;
    logic       motor;
    logic       calor;
    logic       pausa;
    logic       fin;
    logic       rechazo;
    logic [2:0] fase;

    modport master (
        output SECADO, LAVADO, LAVADO_PESADO, puerta_cerrada,
        input  ocupado, valvula, motor, calor, pausa, fin, rechazo, fase
    );

    modport slave (
        input  SECADO, LAVADO, LAVADO_PESADO, puerta_cerrada,
        output ocupado, valvula, motor, calor, pausa, fin, rechazo, fase
    );
endinterface

// File: rtl/lavadora_ciclo.sv
// Washer/dryer cycle executor: accepts one service pulse while idle and walks the
// actuators through timed phases, pausing whenever the door is open.
module lavadora_ciclo #(
    parameter int T_LLENADO       = 4,
    parameter int T_LAVADO        = 8,
    parameter int T_LAVADO_PESADO = 16,
    parameter int T_ENJUAGUE      = 4,
    parameter int T_CENTRIFUGADO  = 6,
    parameter int T_SECADO        = 10,
    parameter int TW              = 8
) (
    input  logic             clk,
    input  logic             rst,
    lavadora_ciclo_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        LLENADO      = 3'd1,
        LAVANDO      = 3'd2,
        ENJUAGUE     = 3'd3,
        CENTRIFUGADO = 3'd4,
        SECANDO      = 3'd5,
        FIN          = 3'd6
    } fase_e;

    typedef enum logic [1:0] {
        SRV_NINGUNO = 2'd0,
        SRV_SECADO  = 2'd1,
        SRV_LAVADO  = 2'd2,
        SRV_PESADO  = 2'd3
    } srv_e;

    // The timer counts T-1 down to 0, so a duration of 2^TW still fits in TW bits.
    localparam logic [TW-1:0] CARGA_LLENADO  = TW'(T_LLENADO - 1);
    localparam logic [TW-1:0] CARGA_LAVADO   = TW'(T_LAVADO - 1);
    localparam logic [TW-1:0] CARGA_PESADO   = TW'(T_LAVADO_PESADO - 1);
    localparam logic [TW-1:0] CARGA_ENJUAGUE = TW'(T_ENJUAGUE - 1);
    localparam logic [TW-1:0] CARGA_CENTRI   = TW'(T_CENTRIFUGADO - 1);
    localparam logic [TW-1:0] CARGA_SECADO   = TW'(T_SECADO - 1);
    localparam logic [TW-1:0] UNO            = TW'(1);

    fase_e           state_reg, state_next;
    srv_e            srv_reg, srv_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            fin_reg, fin_next;
    logic            rechazo_reg, rechazo_next;
    logic            pedido;
    logic [2:0]      act_raw;
    logic [2:0]      act_gated;

    assign pedido = bus.SECADO | bus.LAVADO | bus.LAVADO_PESADO;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            srv_reg     <= SRV_NINGUNO;
            timer_reg   <= '0;
            fin_reg     <= 1'b0;
            rechazo_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            srv_reg     <= srv_next;
            timer_reg   <= timer_next;
            fin_reg     <= fin_next;
            rechazo_reg <= rechazo_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        srv_next     = srv_reg;
        timer_next   = timer_reg;
        fin_next     = 1'b0;
        rechazo_next = (state_reg != IDLE) && pedido;
        case (state_reg)
            IDLE: begin
                if (bus.LAVADO_PESADO) begin
                    srv_next   = SRV_PESADO;
                    state_next = LLENADO;
                    timer_next = CARGA_LLENADO;
                end else if (bus.LAVADO) begin
                    srv_next   = SRV_LAVADO;
                    state_next = LLENADO;
                    timer_next = CARGA_LLENADO;
                end else if (bus.SECADO) begin
                    srv_next   = SRV_SECADO;
                    state_next = SECANDO;
                    timer_next = CARGA_SECADO;
                end
            end
            FIN: begin
                state_next = IDLE;
                srv_next   = SRV_NINGUNO;
                timer_next = '0;
            end
            default: begin
                // Open door freezes both the phase and its remaining count.
                if (bus.puerta_cerrada) begin
                    if (timer_reg != '0) begin
                        timer_next = timer_reg - UNO;
                    end else begin
                        case (state_reg)
                            LLENADO: begin
                                state_next = LAVANDO;
                                timer_next = (srv_reg == SRV_PESADO) ? CARGA_PESADO : CARGA_LAVADO;
                            end
                            LAVANDO: begin
                                state_next = ENJUAGUE;
                                timer_next = CARGA_ENJUAGUE;
                            end
                            ENJUAGUE: begin
                                state_next = CENTRIFUGADO;
                                timer_next = CARGA_CENTRI;
                            end
                            CENTRIFUGADO: begin
                                if (srv_reg == SRV_PESADO) begin
                                    state_next = SECANDO;
                                    timer_next = CARGA_SECADO;
                                end else begin
                                    state_next = FIN;
                                    fin_next   = 1'b1;
                                end
                            end
                            SECANDO: begin
                                state_next = FIN;
                                fin_next   = 1'b1;
                            end
                            default: begin
                                state_next = IDLE;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // Bit order of act_raw: valvula, motor, calor.
    assign act_raw[0] = (state_reg == LLENADO) || (state_reg == ENJUAGUE);
    assign act_raw[1] = (state_reg == LAVANDO) || (state_reg == ENJUAGUE) ||
                        (state_reg == CENTRIFUGADO) || (state_reg == SECANDO);
    assign act_raw[2] = (state_reg == SECANDO) ||
                        ((state_reg == LAVANDO) && (srv_reg == SRV_PESADO));

    for (genvar gi = 0; gi < 3; gi++) begin : g_gate
        assign act_gated[gi] = act_raw[gi] & bus.puerta_cerrada;
    end

    assign bus.valvula = act_gated[0];
    assign bus.motor   = act_gated[1];
    assign bus.calor   = act_gated[2];
    assign bus.ocupado = (state_reg != IDLE);
    assign bus.pausa   = (state_reg != IDLE) && (state_reg != FIN) && !bus.puerta_cerrada;
    assign bus.fin     = fin_reg;
    assign bus.rechazo = rechazo_reg;
    assign bus.fase    = state_reg;

endmodule

// File: tb/tb_lavadora_ciclo.sv
// Self-checking bench for lavadora_ciclo: directed table, multi-cycle corner cases
// and random stimulus compared against a phase-plan queue model.
module tb_lavadora_ciclo;

    localparam int T_LL  = 4;
    localparam int T_LAV = 8;
    localparam int T_PES = 16;
    localparam int T_ENJ = 4;
    localparam int T_CEN = 6;
    localparam int T_SEC = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lavadora_ciclo_if bus ();

    lavadora_ciclo #(
        .T_LLENADO(T_LL), .T_LAVADO(T_LAV), .T_LAVADO_PESADO(T_PES),
        .T_ENJUAGUE(T_ENJ), .T_CENTRIFUGADO(T_CEN), .T_SECADO(T_SEC), .TW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: a cycle is a queue of phases, each with its remaining
    // unpaused cycle count and the actuators it drives.
    typedef struct {
        logic [2:0] fase;
        int         rem;
        logic       v, m, c;
    } ph_t;
    ph_t  plan[$];
    logic m_rech = 1'b0;

    typedef struct {
        logic       s, l, p, d;
        logic [9:0] exp;
    } vec_t;
    vec_t tabla[17];

    function automatic vec_t fila(logic s, logic l, logic p, logic d, logic [9:0] e);
        vec_t r;
        r.s = s; r.l = l; r.p = p; r.d = d; r.exp = e;
        return r;
    endfunction

    function automatic void add(logic [2:0] f, int r, logic v, logic m, logic c);
        ph_t h;
        h.fase = f; h.rem = r; h.v = v; h.m = m; h.c = c;
        plan.push_back(h);
    endfunction

    function automatic void cargar(logic s, logic l, logic p);
        if (p) begin
            add(3'd1, T_LL, 1, 0, 0);  add(3'd2, T_PES, 0, 1, 1);
            add(3'd3, T_ENJ, 1, 1, 0); add(3'd4, T_CEN, 0, 1, 0);
            add(3'd5, T_SEC, 0, 1, 1); add(3'd6, 1, 0, 0, 0);
        end else if (l) begin
            add(3'd1, T_LL, 1, 0, 0);  add(3'd2, T_LAV, 0, 1, 0);
            add(3'd3, T_ENJ, 1, 1, 0); add(3'd4, T_CEN, 0, 1, 0);
            add(3'd6, 1, 0, 0, 0);
        end else if (s) begin
            add(3'd5, T_SEC, 0, 1, 1); add(3'd6, 1, 0, 0, 0);
        end
    endfunction

    function automatic void model_step(logic s, logic l, logic p, logic d);
        ph_t h;
        logic busy;
        busy   = (plan.size() != 0);
        m_rech = busy && (s || l || p);
        if (busy) begin
            h = plan[0];
            if (h.fase == 3'd6) begin
                void'(plan.pop_front());
            end else if (d) begin
                h.rem = h.rem - 1;
                if (h.rem == 0) void'(plan.pop_front());
                else plan[0] = h;
            end
        end else begin
            cargar(s, l, p);
        end
    endfunction

    // {ocupado, valvula, motor, calor, pausa, fin, rechazo, fase}
    function automatic logic [9:0] model_exp(logic d);
        ph_t h;
        if (plan.size() == 0) return {6'b0, m_rech, 3'd0};
        h = plan[0];
        return {1'b1, h.v & d, h.m & d, h.c & d, (!d) && (h.fase != 3'd6),
                h.fase == 3'd6, m_rech, h.fase};
    endfunction

    function automatic logic [9:0] dut_out();
        return {bus.ocupado, bus.valvula, bus.motor, bus.calor, bus.pausa,
                bus.fin, bus.rechazo, bus.fase};
    endfunction

    task automatic compare(string name, logic [9:0] got, logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b required %b at %0t", name, got, exp, $time);
        end else begin
            $display("ok   %s: %b at %0t", name, got, $time);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic cycle(logic s, logic l, logic p, logic d);
        @(negedge clk);
        bus.SECADO = s; bus.LAVADO = l; bus.LAVADO_PESADO = p; bus.puerta_cerrada = d;
        #1;
    endtask

    task automatic advance(logic s, logic l, logic p, logic d);
        @(posedge clk);
        if (rst) model_step(s, l, p, d);
    endtask

    task automatic step_model(string name, logic s, logic l, logic p, logic d);
        cycle(s, l, p, d);
        compare(name, dut_out(), model_exp(d));
        advance(s, l, p, d);
    endtask

    // Issues one request at j=0, keeps the door open for j in [ab_ini, ab_ini+ab_len),
    // and counts busy cycles and fin pulses until the block is idle again.
    task automatic run_service(string name, logic s, logic l, logic p,
                               int ab_ini, int ab_len, int busy_exp);
        int busy;
        int fins;
        bit done;
        logic d;
        busy = 0; fins = 0; done = 0;
        for (int j = 0; j < 300 && !done; j++) begin
            d = !(j >= ab_ini && j < ab_ini + ab_len);
            if (j == 0) cycle(s, l, p, d);
            else        cycle(1'b0, 1'b0, 1'b0, d);
            compare(name, dut_out(), model_exp(d));
            if (bus.ocupado) busy++;
            if (bus.fin) fins++;
            if (j > 0 && !bus.ocupado) done = 1;
            if (j == 0) advance(s, l, p, d);
            else        advance(1'b0, 1'b0, 1'b0, d);
        end
        check_int({name, "_terminated"}, int'(done), 1);
        check_int({name, "_busy_cycles"}, busy, busy_exp);
        check_int({name, "_fin_pulses"}, fins, 1);
    endtask

    initial begin
        bit hit;
        logic s, l, p, d;
        int r;

        tabla[0]  = fila(0, 0, 0, 1, 10'b0000000_000);
        tabla[1]  = fila(1, 0, 0, 1, 10'b0000000_000);
        tabla[2]  = fila(0, 0, 0, 1, 10'b1011000_101);
        tabla[3]  = fila(0, 0, 0, 1, 10'b1011000_101);
        tabla[4]  = fila(0, 1, 0, 1, 10'b1011000_101);
        tabla[5]  = fila(0, 0, 0, 0, 10'b1000101_101);
        tabla[6]  = fila(0, 0, 0, 0, 10'b1000100_101);
        for (int i = 7; i <= 13; i++) tabla[i] = fila(0, 0, 0, 1, 10'b1011000_101);
        tabla[14] = fila(0, 1, 0, 0, 10'b1000010_110);
        tabla[15] = fila(0, 0, 0, 1, 10'b0000001_000);
        tabla[16] = fila(0, 0, 0, 1, 10'b0000000_000);

        bus.SECADO = 0; bus.LAVADO = 0; bus.LAVADO_PESADO = 0; bus.puerta_cerrada = 1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        compare("reset_values", dut_out(), 10'b0);
        rst = 1'b1;

        // Directed SECADO run with a late reject, a door pause and a reject during FIN.
        for (int i = 0; i < 17; i++) begin
            cycle(tabla[i].s, tabla[i].l, tabla[i].p, tabla[i].d);
            compare($sformatf("tabla[%0d]", i), dut_out(), tabla[i].exp);
            advance(tabla[i].s, tabla[i].l, tabla[i].p, tabla[i].d);
        end

        run_service("lavado", 0, 1, 0, 0, 0, 23);
        run_service("lavado_back_to_back", 0, 1, 0, 0, 0, 23);
        run_service("pesado_y_secado", 1, 0, 1, 0, 0, 41);
        run_service("lavado_puerta_5", 0, 1, 0, 7, 5, 28);
        run_service("lavado_puerta_al_aceptar", 0, 1, 0, 0, 4, 26);
        run_service("secado", 1, 0, 0, 0, 0, 11);

        // Asynchronous reset while spinning.
        step_model("rst_prep", 0, 1, 0, 1);
        hit = 0;
        for (int j = 0; j < 40 && !hit; j++) begin
            cycle(0, 0, 0, 1);
            compare("rst_prep", dut_out(), model_exp(1'b1));
            if (bus.fase == 3'd4) hit = 1;
            else advance(0, 0, 0, 1);
        end
        check_int("reached_centrifugado", int'(hit), 1);
        #2;
        rst = 1'b0;
        #1;
        compare("reset_async", dut_out(), 10'b0);
        plan.delete();
        m_rech = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset_held", dut_out(), 10'b0);
        rst = 1'b1;
        run_service("secado_post_reset", 1, 0, 0, 0, 0, 11);

        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 19);
            s = (r == 0) || (r == 3);
            l = (r == 1) || (r == 3);
            p = (r == 2) || (r == 3);
            d = ($urandom_range(0, 7) != 0);
            step_model("random", s, l, p, d);
        end
        repeat (3) step_model("drain", 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lavadora_ciclo.md
# lavadora_ciclo

Service executor for the coin-operated laundry machine. It receives the one-cycle service pulses (SECADO, LAVADO, LAVADO_PESADO) from the payment controller and sequences the washer/dryer actuators through timed phases. It reports busy, pause and completion status, and it rejects any request that arrives while a cycle is already running.

## Interface
- T_LLENADO, 4: fill-phase duration, in cycles
- T_LAVADO, 8: wash-phase duration for a normal wash, in cycles
- T_LAVADO_PESADO, 16: wash-phase duration for a heavy wash, in cycles
- T_ENJUAGUE, 4: rinse-phase duration, in cycles
- T_CENTRIFUGADO, 6: spin-phase duration, in cycles
- T_SECADO, 10: dry-phase duration, in cycles
- TW, 8: timer width; every T_* must be in the range 1..2^TW
- clk  in  1  single system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- SECADO  in  1  one-cycle request for a dry-only cycle
- LAVADO  in  1  one-cycle request for a normal wash
- LAVADO_PESADO  in  1  one-cycle request for a heavy wash plus dry
- puerta_cerrada  in  1  door-closed sensor; 1 = closed
- ocupado  out  1  high whenever the state is not IDLE
- valvula  out  1  water valve drive
- motor  out  1  drum motor drive
- calor  out  1  heater drive
- pausa  out  1  high while a cycle is active and the door is open
- fin  out  1  one-cycle pulse marking cycle completion
- rechazo  out  1  one-cycle pulse marking a rejected request
- fase  out  3  current phase code

## Operation
- **Phase codes:** IDLE=0, LLENADO=1, LAVANDO=2, ENJUAGUE=3, CENTRIFUGADO=4, SECANDO=5, FIN=6.
- **Phase sequences:**
  - SECADO: SECANDO → FIN → IDLE.
  - LAVADO: LLENADO → LAVANDO(T_LAVADO) → ENJUAGUE → CENTRIFUGADO → FIN → IDLE.
  - LAVADO_PESADO: LLENADO → LAVANDO(T_LAVADO_PESADO) → ENJUAGUE → CENTRIFUGADO → SECANDO → FIN → IDLE.
- **Priority:** if several requests are high in the same IDLE cycle, LAVADO_PESADO wins over LAVADO, which wins over SECADO. No rechazo is raised for the losers.
- **Latched request type:** the selected service type is held in a register for the whole cycle. It selects the wash duration and decides whether SECANDO follows CENTRIFUGADO.
- **Actuator decode** (each output is gated by puerta_cerrada):
  - valvula in LLENADO and ENJUAGUE.
  - motor in LAVANDO, ENJUAGUE, CENTRIFUGADO and SECANDO.
  - calor in SECANDO, and in LAVANDO only for a heavy wash.
- **Door open mid-cycle:**
  - Applies in any phase from 1 to 5 while puerta_cerrada=0.
  - The timer holds, the phase holds, all actuators are 0, and pausa=1.
  - When the door closes, the phase resumes with the remaining count.
  - A request accepted with the door open enters its first phase already paused.
- **FIN:** lasts exactly one cycle with fin=1, then the block returns to IDLE. FIN is not paused by an open door.
- **Busy rejection:** any request pulse seen while state≠IDLE (FIN included) is dropped, and rechazo=1 on the next cycle.
- **Reset:** asserting rst at any time, including mid-cycle, immediately forces:
  - IDLE, with fase=0;
  - all outputs 0;
  - timer and latched request type cleared.

## Timing
- **Reset values:** ocupado, valvula, motor, calor, pausa, fin, rechazo = 0 and fase=0.
- **Registered outputs:** state, timer, fin and rechazo are registered. Actuators, ocupado, pausa and fase are decoded from registered state plus puerta_cerrada, so they are Moore outputs except for the door gating.
- **Request acceptance:** a request sampled at edge k moves the state to the first phase after edge k; ocupado rises in that same cycle.
- **Phase timer:**
  - On phase entry the timer loads T−1.
  - It decrements on each edge where the door is closed.
  - When it is 0 and the door is closed, the next edge advances the phase.
  - Each phase therefore occupies exactly T unpaused cycles.
- **Cycle lengths with default parameters** (request at edge k):
  - LAVADO: fin is high after edge k+22 and the state is IDLE after k+23.
  - SECADO: fin is high after k+10 and the state is IDLE after k+11.
  - LAVADO_PESADO: fin is high after k+40 and the state is IDLE after k+41.
- **Pause effect:** each paused cycle extends the total by one cycle.
- **Back-to-back requests:** a request in the cycle immediately after fin (state IDLE) is accepted.
- **Timer width:** the timer is TW bits. A duration of 2^TW loads the all-ones value (2^TW−1), which stays within TW bits; no wrap is permitted.

## Test plan
- **LAVADO pulse at edge 0, door closed:** fase follows 1 (edges 1–4), 2 (5–12), 3 (13–16), 4 (17–22), 6 (23), then 0. valvula, motor and calor match the decode in each phase, and fin pulses exactly once.
- **LAVADO_PESADO and SECADO high simultaneously:** the heavy cycle runs, with calor=1 during LAVANDO and SECANDO and fin after 41 cycles in total. No rechazo is raised.
- **SECADO accepted, LAVADO pulsed 3 cycles later:** rechazo=1 for one cycle and the dry cycle continues unchanged; LAVADO pulsed during FIN also produces rechazo.
- **Door opened for 5 cycles in the middle of LAVANDO:** pausa=1, motor=0 and fase is held at 2. The cycle completes 5 cycles later than nominal.
- **rst asserted asynchronously in CENTRIFUGADO:** all outputs go to 0 without waiting for a clock edge. After release, a new SECADO request runs a clean 11-cycle sequence.
- **Request accepted with the door open:** fase=1 with pausa=1 and valvula=0. The timer does not start until the door closes.
